// File: rtl/hdr_parser_pkg.sv
// Shared definitions for the header parser: FSM states, bus widths and the
// parse-node word layout that the graph compiler also emits.
package hdr_parser_pkg;

  localparam int ADDR_BUS       = 32;
  localparam int DATA_BUS       = 32;
  localparam int NUM_HEADERS    = 16;
  localparam int HDR_ID_W       = 4;
  localparam int NODE_W         = 6;
  localparam int MAX_TRANS      = 15;
  localparam int MAX_HOPS       = 16;
  localparam int PS_NODE_STRIDE = 64;
  localparam int PS_STATE_BUS   = 3;

  localparam logic [DATA_BUS-1:0] ZERO_WORD    = '0;
  localparam logic [NODE_W-1:0]   PARSE_ACCEPT = 6'h3F;

  // Word0 of a parse node
  localparam int NODE_HDR_ID_LSB    = 28;
  localparam int NODE_HDR_LEN_LSB   = 22;
  localparam int NODE_SEL_OFF_LSB   = 16;
  localparam int NODE_SEL_BYTES_LSB = 14;
  localparam int NODE_DEFAULT_LSB   = 8;
  localparam int NODE_NUM_TRANS_LSB = 0;
  // Transition words 1..num_trans
  localparam int TRANS_MATCH_LSB    = 16;
  localparam int TRANS_NEXT_LSB     = 8;

  typedef enum logic [PS_STATE_BUS-1:0] {
    PS_STATE_FREE,
    PS_STATE_NODE,
    PS_STATE_SEL,
    PS_STATE_TRANS,
    PS_STATE_DONE
  } ps_state_e;

  function automatic logic [3:0] clamp_trans(input logic [3:0] n);
    return ({1'b0, n} > 5'(MAX_TRANS)) ? 4'(MAX_TRANS) : n;
  endfunction

  // Select fields are one or two bytes wide; anything else reads one byte.
  function automatic logic [3:0] sel_width(input logic [1:0] sel_bytes);
    return (sel_bytes == 2'd2) ? 4'd2 : 4'd1;
  endfunction

endpackage

// File: rtl/hdr_parser.sv
// Walks a programmable parse graph in packet memory and records the start
// address of every extracted header. Optional macro: PARSER_LOOP_GUARD_EN.
module hdr_parser
  import hdr_parser_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_BUS-1:0] pkt_start_i,
  input  logic [ADDR_BUS-1:0] graph_base_i,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_BUS-1:0] mem_addr_o,
  output logic [3:0]          mem_width_o,
  output logic [DATA_BUS-1:0] mem_data_o,
  input  logic [DATA_BUS-1:0] mem_data_i,
  output logic [DATA_BUS-1:0] parsed_hdrs_o [NUM_HEADERS],
  output logic [NUM_HEADERS-1:0] hdr_valid_o,
  output logic [ADDR_BUS-1:0] payload_o,
  output logic                err_o,
  output logic                ready_o
);

  ps_state_e             state_q;
  logic [ADDR_BUS-1:0]   cur_q;
  logic [ADDR_BUS-1:0]   node_q;
  logic [5:0]            hdr_len_q;
  logic [NODE_W-1:0]     default_next_q;
  logic [3:0]            num_trans_q;
  logic [3:0]            trans_idx_q;
  logic [15:0]           sel_val_q;

  logic [HDR_ID_W-1:0]   f_hdr_id;
  logic [5:0]            f_hdr_len;
  logic [5:0]            f_sel_off;
  logic [1:0]            f_sel_bytes;
  logic [NODE_W-1:0]     f_default;
  logic [3:0]            f_num_trans;
  logic [15:0]           f_match;
  logic [NODE_W-1:0]     f_next;

  logic                  take;
  logic [NODE_W-1:0]     next_node;
  logic [ADDR_BUS-1:0]   cur_next;
  logic [ADDR_BUS-1:0]   next_base;

  assign f_hdr_id    = mem_data_i[NODE_HDR_ID_LSB    +: HDR_ID_W];
  assign f_hdr_len   = mem_data_i[NODE_HDR_LEN_LSB   +: 6];
  assign f_sel_off   = mem_data_i[NODE_SEL_OFF_LSB   +: 6];
  assign f_sel_bytes = mem_data_i[NODE_SEL_BYTES_LSB +: 2];
  assign f_default   = mem_data_i[NODE_DEFAULT_LSB   +: NODE_W];
  assign f_num_trans = mem_data_i[NODE_NUM_TRANS_LSB +: 4];
  assign f_match     = mem_data_i[TRANS_MATCH_LSB    +: 16];
  assign f_next      = mem_data_i[TRANS_NEXT_LSB     +: NODE_W];

  assign mem_we_o   = 1'b0;
  assign mem_data_o = ZERO_WORD;

`ifdef PARSER_LOOP_GUARD_EN
  logic [4:0] hop_q;
  logic       err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Decide whether this cycle leaves the current node, and to where.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    take      = 1'b0;
    next_node = default_next_q;
    case (state_q)
      PS_STATE_SEL:   take = (num_trans_q == 4'd0);
      PS_STATE_TRANS: begin
        if (f_match == sel_val_q) begin
          take      = 1'b1;
          next_node = f_next;
        end else if (trans_idx_q >= num_trans_q) begin
          take = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cur_next  = cur_q + ADDR_BUS'(hdr_len_q);
  assign next_base = graph_base_i + ADDR_BUS'(next_node) * ADDR_BUS'(PS_NODE_STRIDE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= PS_STATE_FREE;
      cur_q          <= '0;
      node_q         <= '0;
      hdr_len_q      <= '0;
      default_next_q <= '0;
      num_trans_q    <= '0;
      trans_idx_q    <= '0;
      sel_val_q      <= '0;
      mem_ce_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_width_o    <= '0;
      hdr_valid_o    <= '0;
      payload_o      <= '0;
      ready_o        <= 1'b0;
      // NOTE: the header table is handed to the executor as-is, so it is a
      // real flop array and is cleared by reset like any other output.
      for (int k = 0; k < NUM_HEADERS; k++) parsed_hdrs_o[k] <= '0;
`ifdef PARSER_LOOP_GUARD_EN
      hop_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        PS_STATE_FREE: begin
          if (start_i) begin
            cur_q       <= pkt_start_i;
            node_q      <= graph_base_i;
            hdr_valid_o <= '0;
            mem_ce_o    <= 1'b1;
            mem_addr_o  <= graph_base_i;
            mem_width_o <= 4'd4;
            state_q     <= PS_STATE_NODE;
`ifdef PARSER_LOOP_GUARD_EN
            hop_q <= 5'd1;
            err_q <= 1'b0;
`endif
          end
        end

        PS_STATE_NODE: begin
          parsed_hdrs_o[f_hdr_id] <= cur_q;
          hdr_valid_o[f_hdr_id]   <= 1'b1;
          hdr_len_q      <= f_hdr_len;
          default_next_q <= f_default;
          num_trans_q    <= clamp_trans(f_num_trans);
          mem_addr_o     <= cur_q + ADDR_BUS'(f_sel_off);
          mem_width_o    <= sel_width(f_sel_bytes);
          state_q        <= PS_STATE_SEL;
        end

        PS_STATE_SEL: begin
          // Read data is zero-extended, so a 1-byte select lands in [7:0].
          sel_val_q <= mem_data_i[15:0];
          if (!take) begin
            trans_idx_q <= 4'd1;
            mem_addr_o  <= node_q + ADDR_BUS'(4);
            mem_width_o <= 4'd4;
            state_q     <= PS_STATE_TRANS;
          end
        end

        PS_STATE_TRANS: begin
          if (!take) begin
            trans_idx_q <= trans_idx_q + 4'd1;
            mem_addr_o  <= node_q + ADDR_BUS'({trans_idx_q + 4'd1, 2'b00});
          end
        end

        PS_STATE_DONE: begin
          if (!start_i) begin
            ready_o <= 1'b0;
            state_q <= PS_STATE_FREE;
          end
        end

        default: state_q <= PS_STATE_FREE;
      endcase

      // Leaving a node: advance past its header and either finish or fetch the next node.
      if (take) begin
        cur_q <= cur_next;
        if (next_node == PARSE_ACCEPT) begin
          payload_o <= cur_next;
          ready_o   <= 1'b1;
          mem_ce_o  <= 1'b0;
          state_q   <= PS_STATE_DONE;
        end
`ifdef PARSER_LOOP_GUARD_EN
        else if (hop_q == 5'(MAX_HOPS)) begin
          payload_o <= cur_next;
          err_q     <= 1'b1;
          ready_o   <= 1'b1;
          mem_ce_o  <= 1'b0;
          state_q   <= PS_STATE_DONE;
        end
`endif
        else begin
          node_q      <= next_base;
          mem_addr_o  <= next_base;
          mem_width_o <= 4'd4;
          state_q     <= PS_STATE_NODE;
`ifdef PARSER_LOOP_GUARD_EN
          hop_q <= hop_q + 5'd1;
`endif
        end
      end
    end
  end

endmodule
